// File: rtl/morse_char_accumulator_pkg.sv
// Shared Morse definitions: symbol codes, symbol width, word-state type and
// the width helper for symbol counters.
package morse_char_accumulator_pkg;

   localparam int SYM_W = 2;

   localparam logic [SYM_W-1:0] MORSE_NONE = 2'b00;
   localparam logic [SYM_W-1:0] MORSE_DOT  = 2'b01;
   localparam logic [SYM_W-1:0] MORSE_LINE = 2'b11;

   typedef enum logic [1:0] {
      W_EMPTY    = 2'd0,
      W_BUILDING = 2'd1,
      W_FULL     = 2'd2
   } word_state_t;

   // Bits needed to hold a symbol count in the range 0..max_symbols.
   function automatic int count_w(input int max_symbols);
      return $clog2(max_symbols + 1);
   endfunction

endpackage

// File: rtl/morse_char_accumulator_fifo.sv
// morse_char_fifo: first-word-fall-through FIFO for committed characters.
// The head entry is visible on pop_data while the FIFO is non-empty. A push
// into a full FIFO is accepted only when a pop happens in the same cycle.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module morse_char_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 13
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level    = wr_ptr_q - rd_ptr_q;
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   // Accept pushes and pops, advance pointers and write the new entry.
   always_comb begin
      do_push  = push && (!full || pop);
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // Pointer registers; only these need a reset to define the FIFO as empty.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage; contents are meaningless until written.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/morse_char_accumulator.sv
// morse_char_accumulator: per-player Morse character builder.
// Dot/line pulses are shifted into a code word; a rising edge on next_input
// commits the word into a small FWFT FIFO read through out_valid/out_ready.
// Optional feature macro MORSE_AUTO_COMMIT_EN: when defined, a word left idle
// for IDLE_CYCLES clocks is committed automatically.
module morse_char_accumulator
   import morse_char_accumulator_pkg::*;
#(
   parameter  int MAX_SYMBOLS = 5,
   parameter  int DEPTH       = 4,
   parameter  int IDLE_CYCLES = 2500,
   localparam int CODE_W      = 2 * MAX_SYMBOLS,
   localparam int CNT_W       = count_w(MAX_SYMBOLS),
   localparam int LVL_W       = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              ld_dot,
   input  logic              ld_line,
   input  logic              next_input,
   input  logic              clear,
   output logic [CODE_W-1:0] cur_code,
   output logic [CNT_W-1:0]  cur_count,
   output logic [CODE_W-1:0] out_code,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LVL_W-1:0]  level,
   output logic              sym_ovf,
   output logic              sym_err,
   output logic              char_drop
);

   localparam int ENTRY_W = CNT_W + CODE_W;

   word_state_t        state_q, state_d;
   logic [CODE_W-1:0]  word_q, word_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               nin_q, nin_d;
   logic               sym_ovf_q, sym_ovf_d;
   logic               sym_err_q, sym_err_d;
   logic               char_drop_q, char_drop_d;

   logic               word_has;
   logic               word_full;
   logic               sym_val;
   logic [SYM_W-1:0]   sym_code;
   logic               edge_commit;
   logic               timeout;
   logic               commit;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] head;

   assign sym_val     = ld_dot ^ ld_line;
   assign sym_code    = ld_line ? MORSE_LINE : MORSE_DOT;
   assign edge_commit = next_input && !nin_q;
   assign commit      = edge_commit || timeout;
   assign pop         = out_valid && out_ready;
   assign nin_d       = next_input;

`ifdef MORSE_AUTO_COMMIT_EN
   localparam int TMR_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

   logic [TMR_W-1:0] idle_q, idle_d;

   // Idle timer: restarts on any symbol, commit or clear, and rests at 0 while no word exists.
   always_comb begin
      timeout = word_has && (idle_q == TMR_W'(IDLE_CYCLES - 1));
      idle_d  = idle_q + TMR_W'(1);
      if (sym_val || !word_has || commit || clear) begin
         idle_d = '0;
      end
   end

   // Idle timer register.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Word FSM state register.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= W_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Word FSM next state, tracking the symbol count the word will hold next cycle.
   always_comb begin
      state_d = W_BUILDING;
      if (count_d == '0) begin
         state_d = W_EMPTY;
      end else if (count_d == CNT_W'(MAX_SYMBOLS)) begin
         state_d = W_FULL;
      end
   end

   // Word FSM outputs.
   always_comb begin
      word_has  = (state_q != W_EMPTY);
      word_full = (state_q == W_FULL);
   end

   // Word update, commit decision and sticky flags; clear outranks commit,
   // and a symbol arriving with clear or commit starts the next word.
   always_comb begin
      word_d      = word_q;
      count_d     = count_q;
      push        = 1'b0;
      sym_ovf_d   = sym_ovf_q;
      sym_err_d   = sym_err_q || (ld_dot && ld_line);
      char_drop_d = char_drop_q;
      if (clear || (commit && word_has)) begin
         if (!clear) begin
            if (!fifo_full || pop) begin
               push = 1'b1;
            end else begin
               char_drop_d = 1'b1;
            end
         end
         if (sym_val) begin
            word_d  = {{(CODE_W-SYM_W){1'b0}}, sym_code};
            count_d = CNT_W'(1);
         end else begin
            word_d  = '0;
            count_d = '0;
         end
      end else if (sym_val) begin
         if (word_full) begin
            sym_ovf_d = 1'b1;
         end else begin
            word_d  = {word_q[CODE_W-SYM_W-1:0], sym_code};
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   // Word, edge-detect and flag registers.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         word_q      <= '0;
         count_q     <= '0;
         nin_q       <= 1'b0;
         sym_ovf_q   <= 1'b0;
         sym_err_q   <= 1'b0;
         char_drop_q <= 1'b0;
      end else begin
         word_q      <= word_d;
         count_q     <= count_d;
         nin_q       <= nin_d;
         sym_ovf_q   <= sym_ovf_d;
         sym_err_q   <= sym_err_d;
         char_drop_q <= char_drop_d;
      end
   end

   morse_char_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (push),
      .push_data ({count_q, word_q}),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   // Head fields are forced to zero while empty so stale storage never shows.
   assign out_valid = !fifo_empty;
   assign out_code  = fifo_empty ? '0 : head[CODE_W-1:0];
   assign out_count = fifo_empty ? '0 : head[ENTRY_W-1:CODE_W];
   assign cur_code  = word_q;
   assign cur_count = count_q;
   assign sym_ovf   = sym_ovf_q;
   assign sym_err   = sym_err_q;
   assign char_drop = char_drop_q;

endmodule
